// File: rtl/ballplayer_pkg.sv
// Shared ballplayer definitions: hand FSM encoding, velocity typing and screen
// geometry used by both the hand-control and ball-physics stages.
package ballplayer_pkg;

  localparam int ROW_W   = 9;
  localparam int VEL_W   = 8;
  localparam int WIDE_W  = VEL_W + 2;
  localparam int SUM_W   = 11;
  localparam int SPEED_W = 8;

  localparam logic [ROW_W-1:0] BALL_FLOOR_Y = 9'd309;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_COAST
  } hand_state_t;

  typedef logic signed [VEL_W-1:0]  vel_t;
  typedef logic signed [WIDE_W-1:0] vel_wide_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Downward strike speed handed to the ball stage; upward motion strikes nothing.
  function automatic logic [SPEED_W-1:0] strike_speed(input vel_t v, input int shift);
    logic [15:0] mag;
    mag = {8'd0, v} << shift;
    if (v <= 0) return '0;
    return (mag > 16'd255) ? 8'hFF : mag[7:0];
  endfunction

endpackage

// File: rtl/hand_control_btn_debounce.sv
// Button conditioner: two-flop synchronizer, history flop, accepted level and
// a one-tick pulse on each accepted rising edge.
module btn_debounce (
  input  logic clk_out,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;
  logic db_q;

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments; blocking ones would let sync2 see this tick's sync1.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      hist  <= sync2;
      // Accept only a level seen on two consecutive ticks.
      if (sync2 == hist && sync2 != db) db <= sync2;
      db_q  <= db;
    end
  end

  assign rise = db & ~db_q;

endmodule

// File: rtl/hand_control.sv
// Paddle motion generator: debounced up/down buttons drive accelerate/coast/clamp
// dynamics. Define HAND_SWING_EN to enable the swing (strike) button with cooldown.
module hand_control
  import ballplayer_pkg::*;
#(
  parameter logic [8:0] MIN_Y          = 9'd40,
  parameter logic [8:0] MAX_Y          = 9'd300,
  parameter logic [8:0] HOME_Y         = 9'd200,
  parameter logic [7:0] ACCEL          = 8'd2,
  parameter logic [7:0] FRICTION       = 8'd1,
  parameter logic [7:0] VMAX           = 8'd24,
  parameter int         VSHIFT         = 2,
  parameter logic [5:0] SWING_COOLDOWN = 6'd16
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       swing_btn,
  input  logic       freeze,
  output logic [8:0] handline,
  output logic [7:0] hand_velocity
);

  // The hand may never be placed on or below the ball floor.
  localparam logic [ROW_W-1:0] FLOOR_LIMIT =
    (MAX_Y < BALL_FLOOR_Y) ? MAX_Y : BALL_FLOOR_Y - 9'd1;

  localparam vel_wide_t ACCEL_W    = vel_wide_t'({2'b00, ACCEL});
  localparam vel_wide_t FRICTION_W = vel_wide_t'({2'b00, FRICTION});
  localparam vel_wide_t VMAX_W     = vel_wide_t'({2'b00, VMAX});
  localparam sum_t      MIN_S      = sum_t'({2'b00, MIN_Y});
  localparam sum_t      MAX_S      = sum_t'({2'b00, FLOOR_LIMIT});

  logic up_db;
  logic down_db;
  logic unused_up_rise;
  logic unused_down_rise;
  logic swing_go;

  btn_debounce u_up (
    .clk_out (clk_out),
    .reset   (reset),
    .raw     (btn_up),
    .db      (up_db),
    .rise    (unused_up_rise)
  );

  btn_debounce u_down (
    .clk_out (clk_out),
    .reset   (reset),
    .raw     (btn_down),
    .db      (down_db),
    .rise    (unused_down_rise)
  );

`ifdef HAND_SWING_EN
  logic       swing_rise;
  logic       unused_swing_db;
  logic [5:0] cooldown;

  btn_debounce u_swing (
    .clk_out (clk_out),
    .reset   (reset),
    .raw     (swing_btn),
    .db      (unused_swing_db),
    .rise    (swing_rise)
  );

  assign swing_go = swing_rise && (cooldown == '0) && !freeze;

  // Cooldown runs through freeze so a frozen hand still re-arms on schedule.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset)                cooldown <= '0;
    else if (swing_go)         cooldown <= SWING_COOLDOWN;
    else if (cooldown != '0)   cooldown <= cooldown - 6'd1;
  end
`else
  localparam logic [5:0] unused_cooldown = SWING_COOLDOWN;
  logic unused_swing;

  assign unused_swing = swing_btn;
  assign swing_go     = 1'b0;
`endif

  hand_state_t      state;
  hand_state_t      state_n;
  vel_t             vel;
  vel_t             vel_n;
  logic [ROW_W-1:0] pos;
  logic [ROW_W-1:0] pos_n;
  logic [7:0]       speed_n;
  vel_wide_t        vel_ext;
  vel_wide_t        trial;
  sum_t             sum;
  logic             move_up;
  logic             move_down;

  // Both buttons together cancel out and count as no button.
  assign move_up   = up_db & ~down_db;
  assign move_down = down_db & ~up_db;

  // NOTE: every variable gets a default at the top of this block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    vel_ext = {{(WIDE_W-VEL_W){vel[VEL_W-1]}}, vel};
    trial   = '0;
    pos_n   = pos;
    vel_n   = '0;
    state_n = ST_IDLE;

    if (swing_go) begin
      trial = VMAX_W;
    end else if (move_up) begin
      trial = vel_ext - ACCEL_W;
      if (trial < -VMAX_W) trial = -VMAX_W;
    end else if (move_down) begin
      trial = vel_ext + ACCEL_W;
      if (trial > VMAX_W) trial = VMAX_W;
    end else if (state != ST_IDLE) begin
      if (vel_ext > FRICTION_W)       trial = vel_ext - FRICTION_W;
      else if (vel_ext < -FRICTION_W) trial = vel_ext + FRICTION_W;
      else                            trial = '0;
    end

    sum = sum_t'({2'b00, pos}) + sum_t'({trial[WIDE_W-1], trial});

    // Hitting a wall kills the velocity, even while the button stays held.
    if (sum < MIN_S) begin
      pos_n = MIN_Y;
      vel_n = '0;
    end else if (sum > MAX_S) begin
      pos_n = FLOOR_LIMIT;
      vel_n = '0;
    end else begin
      pos_n = sum[ROW_W-1:0];
      vel_n = trial[VEL_W-1:0];
    end

    if (swing_go || move_down) state_n = ST_DOWN;
    else if (move_up)          state_n = ST_UP;
    else if (vel_n != '0)      state_n = ST_COAST;
    else                       state_n = ST_IDLE;

    if (freeze) begin
      pos_n   = pos;
      vel_n   = '0;
      state_n = ST_IDLE;
    end

    speed_n = strike_speed(vel_n, VSHIFT);
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      vel           <= '0;
      pos           <= HOME_Y;
      hand_velocity <= '0;
    end else begin
      state         <= state_n;
      vel           <= vel_n;
      pos           <= pos_n;
      hand_velocity <= speed_n;
    end
  end

  assign handline = pos;

endmodule

// File: tb/tb_hand_control.sv
// Directed bench for hand_control: button latency, saturation, walls, coasting,
// glitch rejection, freeze, async reset and (with HAND_SWING_EN) swing/cooldown.
module tb_hand_control;

  logic       clk_out   = 1'b0;
  logic       reset     = 1'b0;
  logic       btn_up    = 1'b0;
  logic       btn_down  = 1'b0;
  logic       swing_btn = 1'b0;
  logic       freeze    = 1'b0;
  logic [8:0] handline;
  logic [7:0] hand_velocity;

  int n_checks = 0;
  int n_errors = 0;

  hand_control dut (
    .clk_out       (clk_out),
    .reset         (reset),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .swing_btn     (swing_btn),
    .freeze        (freeze),
    .handline      (handline),
    .hand_velocity (hand_velocity)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic check_hand(input string tag, input int line, input int speed);
    check({tag, ".handline"}, 16'(handline), 16'(line));
    check({tag, ".hand_velocity"}, 16'(hand_velocity), 16'(speed));
  endtask

  // Advance n rising edges; returns at the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_out);
      @(negedge clk_out);
    end
  endtask

  // Asserts reset away from any edge, checks it acts at once, releases on a
  // falling edge so the next rising edge is edge 1.
  task automatic do_reset(input string tag);
    @(negedge clk_out);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    swing_btn = 1'b0;
    freeze    = 1'b0;
    #2 reset  = 1'b0;
    #1 check_hand({tag, ".reset"}, 200, 0);
    @(negedge clk_out);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset.
    #12 check_hand("por", 200, 0);
    @(negedge clk_out);
    reset = 1'b1;

    // Down from home: latency, acceleration, floor clamp.
    btn_down = 1'b1;
    step(4);  check_hand("down.e4", 200, 0);
    step(1);  check_hand("down.e5", 202, 8);
    step(1);  check_hand("down.e6", 206, 16);
    step(1);  check_hand("down.e7", 212, 24);
    step(4);  check_hand("down.e11", 256, 56);
    step(3);  check_hand("down.floor", 300, 0);
    step(1);  check_hand("down.floor_hold", 300, 0);

    // Up from home to the top wall.
    do_reset("up");
    btn_up = 1'b1;
    step(4);  check_hand("up.e4", 200, 0);
    step(1);  check_hand("up.e5", 198, 0);
    step(1);  check_hand("up.e6", 194, 0);
    step(1);  check_hand("up.e7", 188, 0);
    step(9);  check_hand("up.e16", 44, 0);
    step(1);  check_hand("up.top", 40, 0);
    step(1);  check_hand("up.top_hold", 40, 0);

    // Reverse from the top wall and saturate at VMAX.
    btn_up   = 1'b0;
    btn_down = 1'b1;
    step(4);  check_hand("sat.r4", 40, 0);
    step(1);  check_hand("sat.r5", 42, 8);
    step(11); check_hand("sat.r16", 196, 96);
    step(1);  check_hand("sat.r17", 220, 96);
    btn_down = 1'b0;
    step(3);  check_hand("sat.c3", 292, 96);
    step(1);  check_hand("sat.c4", 300, 0);
    step(1);  check_hand("sat.c5", 300, 0);

    // Short press then coast down to idle.
    do_reset("coast");
    btn_down = 1'b1;
    step(3);
    btn_down = 1'b0;
    step(4);  check_hand("coast.e7", 212, 24);
    step(1);  check_hand("coast.e8", 217, 20);
    step(1);  check_hand("coast.e9", 221, 16);
    step(3);  check_hand("coast.e12", 227, 4);
    step(1);  check_hand("coast.e13", 227, 0);
    step(1);  check_hand("coast.idle", 227, 0);

    // Single-tick glitch and both buttons held.
    do_reset("glitch");
    btn_down = 1'b1;
    step(1);
    btn_down = 1'b0;
    step(8);  check_hand("glitch", 200, 0);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    step(10); check_hand("both", 200, 0);

    // Freeze mid-motion, then resume from zero velocity.
    do_reset("frz");
    btn_down = 1'b1;
    step(9);  check_hand("frz.vel10", 230, 40);
    freeze = 1'b1;
    step(1);  check_hand("frz.e1", 230, 0);
    step(3);  check_hand("frz.e4", 230, 0);
    freeze = 1'b0;
    step(1);  check_hand("frz.resume", 232, 8);

    // Reset mid-motion takes effect without a clock edge.
    do_reset("midrst");
    btn_down = 1'b1;
    step(7);  check_hand("midrst.moving", 212, 24);
    #2 reset = 1'b0;
    #1 check_hand("midrst.async", 200, 0);
    @(negedge clk_out);
    btn_down = 1'b0;
    reset    = 1'b1;

`ifdef HAND_SWING_EN
    // Swing from idle, cooldown rejection, acceptance once cooldown expires.
    do_reset("swing");
    swing_btn = 1'b1;
    step(3);
    swing_btn = 1'b0;
    step(1);  check_hand("swing.e4", 200, 0);
    step(1);  check_hand("swing.e5", 224, 96);
    freeze = 1'b1;
    step(1);  check_hand("swing.freeze", 224, 0);
    freeze = 1'b0;
    step(1);
    swing_btn = 1'b1;
    step(5);  check_hand("swing.cooldown", 224, 0);
    swing_btn = 1'b0;
    step(5);
    swing_btn = 1'b1;
    step(4);  check_hand("swing.e21", 224, 0);
    step(1);  check_hand("swing.rearmed", 248, 96);
    swing_btn = 1'b0;
    step(1);  check_hand("swing.coast", 271, 92);
`else
    // Without the swing feature the strike button does nothing.
    do_reset("noswing");
    swing_btn = 1'b1;
    step(8);  check_hand("noswing", 200, 0);
    swing_btn = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
